// File: rtl/neuron_accumulator.sv
// -----------------------------------------------------------------------------
// neuron_accumulator
//   Neuron MAC back-end. Sums NUM_INPUTS signed products from the
//   two's-complement stage, adds the neuron bias, and hands one registered
//   pre-activation sum per evaluation to the activation stage with a
//   single-cycle valid strobe.
//
// Configuration macro:
//   ACC_SATURATE_EN  defined   -> every add (accumulate and bias) clamps to
//                                 the signed range on overflow.
//                    undefined -> every add wraps modulo 2^DATA_WIDTH.
//
// Ports:
//   clk        in   1           sole clock, all state updates on posedge
//   rstn       in   1           synchronous active-low reset
//   i_valid    in   1           i_prod is valid this cycle
//   i_prod     in   DATA_WIDTH  signed product
//   i_bias     in   DATA_WIDTH  signed bias, sampled only in the BIAS cycle
//   o_sum      out  DATA_WIDTH  signed sum, held until the next result
//   o_valid    out  1           one-cycle strobe: o_sum is new
//   o_overrun  out  1           sticky: a product arrived in BIAS and was dropped
// -----------------------------------------------------------------------------
module neuron_accumulator #(
  parameter int NUM_INPUTS = 784,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_prod,
  input  logic [DATA_WIDTH-1:0] i_bias,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_valid,
  output logic                  o_overrun
);

  localparam int CNT_W = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_BIAS = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // Signed add of two DATA_WIDTH operands; clamps or wraps per build option.
  function automatic logic [DATA_WIDTH-1:0] acc_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] result;
`ifdef ACC_SATURATE_EN
    logic [DATA_WIDTH:0] ext;
    ext = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    // The two top bits of the sign-extended sum disagree exactly when the
    // operand signs match and the truncated result sign differs.
    if (ext[DATA_WIDTH] != ext[DATA_WIDTH-1]) begin
      if (ext[DATA_WIDTH]) begin
        result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      result = ext[DATA_WIDTH-1:0];
    end
`else
    result = a + b;
`endif
    return result;
  endfunction

  logic [0:0]            state_r,    state_s;
  logic [CNT_W-1:0]      count_r,    count_s;
  logic [DATA_WIDTH-1:0] sum_r,      sum_s;
  logic [DATA_WIDTH-1:0] sum_out_r,  sum_out_s;
  logic                  valid_r,    valid_s;
  logic                  overrun_r,  overrun_s;

  // Next-state logic for the ACC/BIAS sequencer and the datapath.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    sum_s     = sum_r;
    sum_out_s = sum_out_r;
    valid_s   = 1'b0;
    overrun_s = overrun_r;
    case (state_r)
      ST_ACC: begin
        if (i_valid) begin
          sum_s = acc_add(sum_r, i_prod);
          if (count_r == CNT_LAST) begin
            count_s = {CNT_W{1'b0}};
            state_s = ST_BIAS;
          end else begin
            count_s = count_r + CNT_ONE;
          end
        end else begin
          sum_s = sum_r;
        end
      end
      ST_BIAS: begin
        // One cycle only: fold in the bias, publish, and restart accumulation.
        sum_out_s = acc_add(sum_r, i_bias);
        valid_s   = 1'b1;
        sum_s     = {DATA_WIDTH{1'b0}};
        count_s   = {CNT_W{1'b0}};
        state_s   = ST_ACC;
        if (i_valid) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
      end
      default: begin
        state_s = ST_ACC;
        count_s = {CNT_W{1'b0}};
        sum_s   = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= ST_ACC;
      count_r   <= {CNT_W{1'b0}};
      sum_r     <= {DATA_WIDTH{1'b0}};
      sum_out_r <= {DATA_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      sum_r     <= sum_s;
      sum_out_r <= sum_out_s;
      valid_r   <= valid_s;
      overrun_r <= overrun_s;
    end
  end

  assign o_sum     = sum_out_r;
  assign o_valid   = valid_r;
  assign o_overrun = overrun_r;

endmodule

// File: tb/tb_neuron_accumulator.sv
// -----------------------------------------------------------------------------
// tb_neuron_accumulator
//   Directed scoreboard bench for neuron_accumulator with NUM_INPUTS=4,
//   DATA_WIDTH=32. The driver pushes hand-computed expected results into a
//   queue; an independent monitor pops and compares on every o_valid.
// -----------------------------------------------------------------------------
module tb_neuron_accumulator;

  logic        clk;
  logic        rstn;
  logic        i_valid;
  logic [31:0] i_prod;
  logic [31:0] i_bias;
  logic [31:0] o_sum;
  logic        o_valid;
  logic        o_overrun;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  neuron_accumulator #(
    .NUM_INPUTS(4),
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_valid  (i_valid),
    .i_prod   (i_prod),
    .i_bias   (i_bias),
    .o_sum    (o_sum),
    .o_valid  (o_valid),
    .o_overrun(o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every o_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (rstn && o_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_sum %h with no result pending", o_sum);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_sum", o_sum, e.sum);
        check("sb_overrun", {31'd0, o_overrun}, {31'd0, e.ovr});
      end
    end
  end

  // One evaluation: products with gap idle cycles before each, then BIAS cycle.
  task automatic run_eval(input string name,
                          input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3,
                          input logic [31:0] b, input int gap_seed,
                          input logic inject, input logic [31:0] exp_sum,
                          input logic exp_ovr);
    logic [31:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    i_bias = b;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < ((gap_seed + i) % 4); g++) begin
        i_valid = 1'b0;
        i_prod  = 32'hDEAD_BEEF;
        step();
      end
      i_valid = 1'b1;
      i_prod  = p[i];
      step();
      i_valid = 1'b0;
    end
    sb_q.push_back('{sum: exp_sum, ovr: exp_ovr});
    // Last product just captured: strobe must not have fired yet.
    check({name, "_pre_valid"}, {31'd0, o_valid}, 32'd0);
    if (inject) begin
      i_valid = 1'b1;
      i_prod  = 32'd1000;
    end else begin
      i_valid = 1'b0;
    end
    step();
    i_valid = 1'b0;
    check({name, "_latency_valid"}, {31'd0, o_valid}, 32'd1);
    step();
    check({name, "_strobe_width"}, {31'd0, o_valid}, 32'd0);
  endtask

  logic [31:0] exp3, exp4, exp_bov;

  initial begin
    rstn    = 1'b0;
    i_valid = 1'b0;
    i_prod  = 32'd0;
    i_bias  = 32'd0;
`ifdef ACC_SATURATE_EN
    exp3    = 32'h7FFF_FFFF;
    exp4    = 32'h8000_0000;
    exp_bov = 32'h7FFF_FFFF;
`else
    exp3    = 32'h8000_0001;
    exp4    = 32'h7FFF_FFFF;
    exp_bov = 32'h8000_0000;
`endif
    repeat (3) step();
    check("reset_sum", o_sum, 32'd0);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_overrun", {31'd0, o_overrun}, 32'd0);
    rstn = 1'b1;
    step();

    // 1: back-to-back products
    run_eval("t1", 32'd100, -32'sd50, 32'd25, 32'd5, 32'd20, 0, 1'b0, 32'd100, 1'b0);
    // 2: same products with 0-3 idle cycles between them
    for (int s = 1; s < 4; s++) begin
      run_eval("t2", 32'd100, -32'sd50, 32'd25, 32'd5, 32'd20, s, 1'b0, 32'd100, 1'b0);
    end
    // Negative result
    run_eval("neg", -32'sd10, -32'sd20, -32'sd30, -32'sd40, 32'd5, 0, 1'b0, 32'hFFFF_FFA1, 1'b0);
    // 3: positive overflow in accumulation
    run_eval("t3", 32'h7FFF_FFF0, 32'h0000_0010, 32'd0, 32'd0, 32'd1, 0, 1'b0, exp3, 1'b0);
    // 4: negative overflow in accumulation
    run_eval("t4", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 0, 1'b0, exp4, 1'b0);
    // Overflow only in the bias add
    run_eval("bias_ovf", 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1, 0, 1'b0, exp_bov, 1'b0);

    // 5: reset mid-evaluation discards the partial sum
    i_valid = 1'b1; i_prod = 32'd500; step();
    i_prod  = 32'd600; step();
    i_valid = 1'b0;
    rstn    = 1'b0;
    step();
    check("t5_rst_sum", o_sum, 32'd0);
    check("t5_rst_valid", {31'd0, o_valid}, 32'd0);
    check("t5_rst_overrun", {31'd0, o_overrun}, 32'd0);
    rstn = 1'b1;
    step();
    run_eval("t5", 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 0, 1'b0, 32'd10, 1'b0);

    // 6: product during BIAS is dropped and flagged; next sum excludes it
    check("t6_overrun_before", {31'd0, o_overrun}, 32'd0);
    run_eval("t6", 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 0, 1'b1, 32'd4, 1'b1);
    run_eval("t6_next", 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 0, 1'b0, 32'd10, 1'b1);
    repeat (3) step();
    check("t6_overrun_sticky", {31'd0, o_overrun}, 32'd1);

    // Scoreboard must have drained
    for (int w = 0; w < 20 && sb_q.size() != 0; w++) step();
    check("sb_drain", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
